// File: rtl/workers_cpu_mul_pkg.sv
// Shared definitions for the worker-CPU pipelined multiplier: op-mode encodings,
// operand signedness per mode and the half-width limb derivation.
package workers_cpu_mul_pkg;

   localparam logic [1:0] MUL_MODE_MUL    = 2'b00;
   localparam logic [1:0] MUL_MODE_MULH   = 2'b01;
   localparam logic [1:0] MUL_MODE_MULHSU = 2'b10;
   localparam logic [1:0] MUL_MODE_MULHU  = 2'b11;

   typedef struct packed {
      logic a_signed;
      logic b_signed;
   } mul_sign_t;

   // MUL returns the low half, which is identical for any signedness; treat it as unsigned.
   function automatic mul_sign_t mode_signedness(input logic [1:0] mode);
      mul_sign_t s;
      s = '{a_signed: 1'b0, b_signed: 1'b0};
      case (mode)
         MUL_MODE_MULH:   s = '{a_signed: 1'b1, b_signed: 1'b1};
         MUL_MODE_MULHSU: s = '{a_signed: 1'b1, b_signed: 1'b0};
         default:         s = '{a_signed: 1'b0, b_signed: 1'b0};
      endcase
      return s;
   endfunction

   function automatic int unsigned half_width(input int unsigned width);
      return width / 2;
   endfunction

endpackage

// File: rtl/workers_cpu_mul_partial_cell.sv
// One registered signed OP_W x OP_W multiplier with load enable and async clear;
// shaped so synthesis maps each instance onto a single DSP block.
module workers_cpu_mul_partial_cell #(
   parameter int unsigned OP_W = 17
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       i_en,
   input  logic signed [OP_W-1:0]     i_a,
   input  logic signed [OP_W-1:0]     i_b,
   output logic signed [2*OP_W-1:0]   o_p
);

   logic signed [2*OP_W-1:0] r_p;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_p <= '0;
      end else if (i_en) begin
         r_p <= i_a * i_b;
      end
   end

   assign o_p = r_p;

endmodule

// File: rtl/workers_cpu_mul_pipe.sv
// Two-stage pipelined WIDTH x WIDTH multiplier: stage 1 registers four half-width partial
// products, stage 2 sums them and registers the selected half with its tag.
module workers_cpu_mul_pipe
   import workers_cpu_mul_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned TAG_W = 5
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_mode,
   input  logic [WIDTH-1:0] in_src1,
   input  logic [WIDTH-1:0] in_src2,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic [TAG_W-1:0] out_tag
);

   localparam int unsigned HALF = half_width(WIDTH);
   localparam int unsigned PW   = 2 * HALF + 2;
   localparam int unsigned EXT  = 2 * WIDTH - PW;

   // Handshake: a transfer happens on a rising edge where valid && ready are both high.
   // Producers hold valid/data until taken; ready never depends on the opposite valid.
   logic       w_stall;
   logic       w_accept;
   mul_sign_t  w_sign;

   logic signed [HALF:0] w_a_lo, w_a_hi, w_b_lo, w_b_hi;
   logic signed [PW-1:0] w_p_ll, w_p_lh, w_p_hl, w_p_hh;

   logic [2*WIDTH-1:0] w_ll_ext, w_lh_ext, w_hl_ext, w_hh_ext;
   logic [2*WIDTH-1:0] w_mid, w_prod;
   logic [WIDTH-1:0]   w_result;

   logic             r_v1;
   logic [1:0]       r_mode1;
   logic [TAG_W-1:0] r_tag1;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_out_result;
   logic [TAG_W-1:0] r_out_tag;

   assign w_stall  = r_out_valid && !out_ready;
   assign in_ready = !w_stall && !flush;
   assign w_accept = in_valid && in_ready;

   // Low limbs are always unsigned; high limbs carry the operand sign when the mode asks.
   assign w_sign = mode_signedness(in_mode);
   assign w_a_lo = {1'b0, in_src1[HALF-1:0]};
   assign w_b_lo = {1'b0, in_src2[HALF-1:0]};
   assign w_a_hi = {w_sign.a_signed & in_src1[WIDTH-1], in_src1[WIDTH-1:HALF]};
   assign w_b_hi = {w_sign.b_signed & in_src2[WIDTH-1], in_src2[WIDTH-1:HALF]};

   workers_cpu_mul_partial_cell #(.OP_W(HALF + 1)) u_cell_ll (
      .clk(clk), .reset_n(reset_n), .i_en(w_accept), .i_a(w_a_lo), .i_b(w_b_lo), .o_p(w_p_ll)
   );
   workers_cpu_mul_partial_cell #(.OP_W(HALF + 1)) u_cell_lh (
      .clk(clk), .reset_n(reset_n), .i_en(w_accept), .i_a(w_a_lo), .i_b(w_b_hi), .o_p(w_p_lh)
   );
   workers_cpu_mul_partial_cell #(.OP_W(HALF + 1)) u_cell_hl (
      .clk(clk), .reset_n(reset_n), .i_en(w_accept), .i_a(w_a_hi), .i_b(w_b_lo), .o_p(w_p_hl)
   );
   workers_cpu_mul_partial_cell #(.OP_W(HALF + 1)) u_cell_hh (
      .clk(clk), .reset_n(reset_n), .i_en(w_accept), .i_a(w_a_hi), .i_b(w_b_hi), .o_p(w_p_hh)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_v1    <= 1'b0;
         r_mode1 <= MUL_MODE_MUL;
         r_tag1  <= '0;
      end else if (flush) begin
         r_v1 <= 1'b0;
      end else if (!w_stall) begin
         r_v1 <= w_accept;
         if (w_accept) begin
            r_mode1 <= in_mode;
            r_tag1  <= in_tag;
         end
      end
   end

   // Sign-extend each partial product and sum modulo 2^(2*WIDTH).
   assign w_ll_ext = {{EXT{w_p_ll[PW-1]}}, w_p_ll};
   assign w_lh_ext = {{EXT{w_p_lh[PW-1]}}, w_p_lh};
   assign w_hl_ext = {{EXT{w_p_hl[PW-1]}}, w_p_hl};
   assign w_hh_ext = {{EXT{w_p_hh[PW-1]}}, w_p_hh};
   assign w_mid    = w_lh_ext + w_hl_ext;
   assign w_prod   = (w_hh_ext << WIDTH) + (w_mid << HALF) + w_ll_ext;
   assign w_result = (r_mode1 == MUL_MODE_MUL) ? w_prod[WIDTH-1:0] : w_prod[2*WIDTH-1:WIDTH];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_out_valid  <= 1'b0;
         r_out_result <= '0;
         r_out_tag    <= '0;
      end else if (flush) begin
         r_out_valid <= 1'b0;
      end else if (!w_stall) begin
         r_out_valid <= r_v1;
         if (r_v1) begin
            r_out_result <= w_result;
            r_out_tag    <= r_tag1;
         end
      end
   end

   assign out_valid  = r_out_valid;
   assign out_result = r_out_result;
   assign out_tag    = r_out_tag;

endmodule

// File: tb/tb_workers_cpu_mul_pipe.sv
// Self-checking bench for workers_cpu_mul_pipe: directed corner cases, stall, flush and
// reset scenarios at WIDTH=32, plus a random sweep of a WIDTH=16 instance.
module tb_workers_cpu_mul_pipe;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [1:0]  in_mode = 2'd0;
   logic [31:0] in_src1 = '0;
   logic [31:0] in_src2 = '0;
   logic [4:0]  in_tag = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_result;
   logic [4:0]  out_tag;

   logic        flush16 = 1'b0;
   logic        v16 = 1'b0;
   logic        rdy16;
   logic [1:0]  m16 = 2'd0;
   logic [15:0] a16 = '0;
   logic [15:0] b16 = '0;
   logic [4:0]  t16 = '0;
   logic        ov16;
   logic        or16 = 1'b1;
   logic [15:0] res16;
   logic [4:0]  otag16;

   int checks = 0;
   int errors = 0;
   int unexpected = 0;

   logic [31:0] exp_q[$];
   logic [4:0]  exp_tag_q[$];
   logic [31:0] done_exp_q[$];
   logic [4:0]  done_tag_q[$];
   logic [31:0] got_q[$];
   logic [4:0]  got_tag_q[$];

   workers_cpu_mul_pipe #(.WIDTH(32), .TAG_W(5)) dut (
      .clk(clk), .reset_n(reset_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
      .in_src1(in_src1), .in_src2(in_src2), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_tag(out_tag)
   );

   workers_cpu_mul_pipe #(.WIDTH(16), .TAG_W(5)) dut16 (
      .clk(clk), .reset_n(reset_n), .flush(flush16),
      .in_valid(v16), .in_ready(rdy16), .in_mode(m16),
      .in_src1(a16), .in_src2(b16), .in_tag(t16),
      .out_valid(ov16), .out_ready(or16),
      .out_result(res16), .out_tag(otag16)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Reference: widen both operands to 64 bits with the mode's sign rule, multiply, pick a half.
   function automatic logic [31:0] ref_mul(input int w, input logic [1:0] mode,
                                           input logic [31:0] a, input logic [31:0] b);
      logic [63:0] mask, ax, bx, p, r;
      logic        as, bs;
      as   = (mode == 2'd1) || (mode == 2'd2);
      bs   = (mode == 2'd1);
      mask = (64'd1 << w) - 64'd1;
      ax   = {32'h0, a} & mask;
      bx   = {32'h0, b} & mask;
      if (as && a[w-1]) ax = ax | ~mask;
      if (bs && b[w-1]) bx = bx | ~mask;
      p = ax * bx;
      r = (mode == 2'd0) ? (p & mask) : ((p >> w) & mask);
      return r[31:0];
   endfunction

   task automatic clear_sb();
      exp_q.delete(); exp_tag_q.delete();
      done_exp_q.delete(); done_tag_q.delete();
      got_q.delete(); got_tag_q.delete();
      unexpected = 0;
   endtask

   // Drive one cycle at the falling edge, then log the transfers the next rising edge will make.
   task automatic step(input logic iv, input logic [1:0] m, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] t, input logic ordy, input logic fl);
      @(negedge clk);
      in_valid = iv; in_mode = m; in_src1 = a; in_src2 = b; in_tag = t;
      out_ready = ordy; flush = fl;
      #1;
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            unexpected++;
         end else begin
            done_exp_q.push_back(exp_q.pop_front());
            done_tag_q.push_back(exp_tag_q.pop_front());
         end
         got_q.push_back(out_result);
         got_tag_q.push_back(out_tag);
      end
      if (in_valid && in_ready) begin
         exp_q.push_back(ref_mul(32, m, a, b));
         exp_tag_q.push_back(t);
      end
      if (fl) begin
         exp_q.delete();
         exp_tag_q.delete();
      end
   endtask

   task automatic run_single(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] t, output logic acc, output logic [31:0] res,
                             output logic [4:0] tg, output int lat);
      @(negedge clk);
      in_valid = 1'b1; in_mode = m; in_src1 = a; in_src2 = b; in_tag = t;
      out_ready = 1'b1; flush = 1'b0;
      #1;
      acc = in_ready;
      res = '0; tg = '0; lat = -1;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         in_valid = 1'b0;
         #1;
         if (out_valid) begin
            res = out_result; tg = out_tag; lat = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checks += 4;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      if (out_result !== 32'h0) begin errors++; $display("FAIL reset_out_result: got %h expected 0", out_result); end
      if (out_tag !== 5'h0) begin errors++; $display("FAIL reset_out_tag: got %h expected 0", out_tag); end
      if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_basic();
      logic acc; logic [31:0] res; logic [4:0] tg; int lat;
      run_single(2'd0, 32'h7, 32'h6, 5'd9, acc, res, tg, lat);
      checks += 4;
      if (acc !== 1'b1) begin errors++; $display("FAIL basic_accept: in_ready %b expected 1", acc); end
      if (lat != 2) begin errors++; $display("FAIL basic_latency: got %0d cycles expected 2", lat); end
      if (res !== 32'h2A) begin errors++; $display("FAIL basic_result: got %h expected 0000002a", res); end
      if (tg !== 5'd9) begin errors++; $display("FAIL basic_tag: got %0d expected 9", tg); end
      @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_retire: out_valid %b expected 0", out_valid); end
   endtask

   task automatic test_corners();
      logic [1:0]  modes[7] = '{2'd1, 2'd3, 2'd2, 2'd0, 2'd1, 2'd0, 2'd3};
      logic [31:0] ops[7]   = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                32'h80000000, 32'h80000000, 32'h80000000};
      logic [31:0] want[7]  = '{32'h00000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000001,
                                32'h40000000, 32'h00000000, 32'h40000000};
      logic acc; logic [31:0] res; logic [4:0] tg; int lat;
      for (int i = 0; i < 7; i++) begin
         run_single(modes[i], ops[i], ops[i], 5'(i + 20), acc, res, tg, lat);
         checks += 2;
         if (lat != 2) begin errors++; $display("FAIL corner[%0d]_latency: got %0d expected 2", i, lat); end
         if (res !== want[i]) begin
            errors++;
            $display("FAIL corner[%0d]_result mode %0d: got %h expected %h", i, modes[i], res, want[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      clear_sb();
      for (int i = 1; i <= 3; i++) step(1'b1, 2'(i), $urandom, $urandom, 5'(i), 1'b1, 1'b0);
      for (int i = 0; i < 2; i++) begin
         step(1'b1, 2'd0, 32'h5, 32'h5, 5'd7, 1'b0, 1'b0);
         checks += 2;
         if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_stall_in_ready[%0d]: got %b expected 0", i, in_ready); end
         if (out_tag !== 5'd2) begin errors++; $display("FAIL b2b_stall_hold[%0d]: out_tag %0d expected 2", i, out_tag); end
      end
      repeat (5) step(1'b0, 2'd0, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0);
      checks += 2;
      if (got_q.size() != 3 || unexpected != 0) begin
         errors++; $display("FAIL b2b_count: got %0d results (%0d unexpected) expected 3", got_q.size(), unexpected);
      end
      if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_dropped: %0d pending expected 0", exp_q.size()); end
      for (int i = 0; i < got_q.size() && i < done_exp_q.size(); i++) begin
         checks++;
         if (got_q[i] !== done_exp_q[i] || got_tag_q[i] !== 5'(i + 1)) begin
            errors++;
            $display("FAIL b2b_result[%0d]: got %h tag %0d expected %h tag %0d",
                     i, got_q[i], got_tag_q[i], done_exp_q[i], i + 1);
         end
      end
   endtask

   task automatic test_flush();
      logic [31:0] a, b;
      clear_sb();
      a = $urandom; b = $urandom;
      step(1'b1, 2'd0, 32'h11, 32'h22, 5'd10, 1'b1, 1'b0);
      step(1'b1, 2'd3, 32'h33, 32'h44, 5'd11, 1'b1, 1'b0);
      step(1'b1, 2'd1, 32'h55, 32'h66, 5'd12, 1'b0, 1'b1);
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b expected 0", in_ready); end
      step(1'b1, 2'd2, a, b, 5'd13, 1'b1, 1'b0);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_killed_c1: out_valid %b expected 0", out_valid); end
      step(1'b0, 2'd0, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_killed_c2: out_valid %b expected 0", out_valid); end
      step(1'b0, 2'd0, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0);
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_next_op_valid: out_valid %b expected 1", out_valid); end
      repeat (3) step(1'b0, 2'd0, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0);
      checks += 2;
      if (got_q.size() != 1 || unexpected != 0) begin
         errors++; $display("FAIL flush_count: got %0d results (%0d unexpected) expected 1", got_q.size(), unexpected);
      end
      if (got_q.size() >= 1 && (got_q[0] !== ref_mul(32, 2'd2, a, b) || got_tag_q[0] !== 5'd13)) begin
         errors++;
         $display("FAIL flush_next_op_result: got %h tag %0d expected %h tag 13",
                  got_q[0], got_tag_q[0], ref_mul(32, 2'd2, a, b));
      end
   endtask

   task automatic test_random32();
      clear_sb();
      for (int c = 0; c < 300; c++) begin
         step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, $urandom,
              5'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 39) == 0));
      end
      repeat (6) step(1'b0, 2'd0, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0);
      checks += 2;
      if (unexpected != 0 || got_q.size() != done_exp_q.size()) begin
         errors++; $display("FAIL rand32_count: %0d unexpected results", unexpected);
      end
      if (exp_q.size() != 0) begin errors++; $display("FAIL rand32_dropped: %0d pending expected 0", exp_q.size()); end
      for (int i = 0; i < got_q.size() && i < done_exp_q.size(); i++) begin
         checks++;
         if (got_q[i] !== done_exp_q[i] || got_tag_q[i] !== done_tag_q[i]) begin
            errors++;
            $display("FAIL rand32_result[%0d]: got %h tag %0d expected %h tag %0d",
                     i, got_q[i], got_tag_q[i], done_exp_q[i], done_tag_q[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic acc; logic [31:0] res, a, b; logic [4:0] tg; int lat;
      clear_sb();
      step(1'b1, 2'd0, 32'h3, 32'h5, 5'd17, 1'b0, 1'b0);
      step(1'b1, 2'd0, 32'h9, 32'h9, 5'd18, 1'b0, 1'b0);
      step(1'b0, 2'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre_valid: out_valid %b expected 1", out_valid); end
      #1;
      reset_n = 1'b0;
      #1;
      checks += 3;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid: got %b expected 0", out_valid); end
      if (out_result !== 32'h0) begin errors++; $display("FAIL rstmid_out_result: got %h expected 0", out_result); end
      if (out_tag !== 5'h0) begin errors++; $display("FAIL rstmid_out_tag: got %0d expected 0", out_tag); end
      @(negedge clk);
      reset_n = 1'b1;
      a = $urandom; b = $urandom;
      run_single(2'd3, a, b, 5'd21, acc, res, tg, lat);
      checks += 3;
      if (lat != 2) begin errors++; $display("FAIL rstmid_after_latency: got %0d expected 2", lat); end
      if (res !== ref_mul(32, 2'd3, a, b)) begin
         errors++; $display("FAIL rstmid_after_result: got %h expected %h", res, ref_mul(32, 2'd3, a, b));
      end
      if (tg !== 5'd21) begin errors++; $display("FAIL rstmid_after_tag: got %0d expected 21", tg); end
   endtask

   task automatic test_width16();
      logic [15:0] q16[$];
      logic [4:0]  tq16[$];
      logic [31:0] e;
      logic [15:0] e16;
      logic [4:0]  et;
      for (int c = 0; c < 406; c++) begin
         @(negedge clk);
         if (c < 400) begin
            v16 = 1'($urandom_range(0, 1)); m16 = 2'($urandom_range(0, 3));
            a16 = 16'($urandom); b16 = 16'($urandom); t16 = 5'($urandom);
            or16 = ($urandom_range(0, 3) != 0);
         end else begin
            v16 = 1'b0; or16 = 1'b1;
         end
         #1;
         if (ov16 && or16) begin
            checks++;
            if (q16.size() == 0) begin
               errors++; $display("FAIL w16_unexpected: result %h tag %0d with nothing pending", res16, otag16);
            end else begin
               e16 = q16.pop_front(); et = tq16.pop_front();
               if (res16 !== e16 || otag16 !== et) begin
                  errors++; $display("FAIL w16_result: got %h tag %0d expected %h tag %0d", res16, otag16, e16, et);
               end
            end
         end
         if (v16 && rdy16) begin
            e = ref_mul(16, m16, {16'h0, a16}, {16'h0, b16});
            q16.push_back(e[15:0]);
            tq16.push_back(t16);
         end
      end
      checks++;
      if (q16.size() != 0) begin errors++; $display("FAIL w16_dropped: %0d pending expected 0", q16.size()); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_corners();
      test_back_to_back();
      test_flush();
      test_random32();
      test_reset_mid();
      test_width16();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
